// File: rtl/timer_bank.sv
// timer_bank: bank of independent programmable interval timers.
// Each channel has its own period, direction, one-shot mode and enable.
// Each channel drives a registered one-cycle tick, a 50% square wave,
// a one-shot done flag and its live counter value.
module timer_bank #(
   parameter int unsigned     WIDTH          = 32,
   parameter int unsigned     CHANNELS       = 2,
   parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(50_000_000)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [3:0]                wr_ch,
   input  logic [WIDTH-1:0]          wr_period,
   input  logic [CHANNELS-1:0]       enable,
   input  logic [CHANNELS-1:0]       up_not_down,
   input  logic [CHANNELS-1:0]       one_shot,
   output logic [CHANNELS-1:0]       tick,
   output logic [CHANNELS-1:0]       square,
   output logic [CHANNELS-1:0]       done,
   output logic [CHANNELS*WIDTH-1:0] count_flat
);

   localparam logic [WIDTH-1:0] DEFAULT_TOP = DEFAULT_PERIOD - 1'b1;

   logic [WIDTH-1:0]    r_period [CHANNELS];
   logic [WIDTH-1:0]    r_count  [CHANNELS];
   logic [CHANNELS-1:0] r_tick;
   logic [CHANNELS-1:0] r_square;
   logic [CHANNELS-1:0] r_done;

   logic [WIDTH-1:0]    w_period_nxt [CHANNELS];
   logic [WIDTH-1:0]    w_count_nxt  [CHANNELS];
   logic [CHANNELS-1:0] w_tick_nxt;
   logic [CHANNELS-1:0] w_square_nxt;
   logic [CHANNELS-1:0] w_done_nxt;

   // Per-channel next state: a write wins over counting; a wrap raises tick,
   // toggles square, reloads the start value and latches done in one-shot mode.
   always_comb begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         w_period_nxt[i] = r_period[i];
         w_count_nxt[i]  = r_count[i];
         w_tick_nxt[i]   = 1'b0;
         w_square_nxt[i] = r_square[i];
         w_done_nxt[i]   = r_done[i];
         if (wr_en && (32'(wr_ch) == i)) begin
            w_period_nxt[i] = wr_period;
            // A zero period parks the counter at 0 regardless of direction.
            if (up_not_down[i] || (wr_period == '0)) begin
               w_count_nxt[i] = '0;
            end else begin
               w_count_nxt[i] = wr_period - 1'b1;
            end
            w_done_nxt[i] = 1'b0;
         end else if (enable[i] && !r_done[i] && (r_period[i] != '0)) begin
            if (up_not_down[i]) begin
               if (r_count[i] == r_period[i] - 1'b1) begin
                  w_count_nxt[i]  = '0;
                  w_tick_nxt[i]   = 1'b1;
                  w_square_nxt[i] = ~r_square[i];
                  w_done_nxt[i]   = one_shot[i];
               end else begin
                  w_count_nxt[i] = r_count[i] + 1'b1;
               end
            end else begin
               if (r_count[i] == '0) begin
                  w_count_nxt[i]  = r_period[i] - 1'b1;
                  w_tick_nxt[i]   = 1'b1;
                  w_square_nxt[i] = ~r_square[i];
                  w_done_nxt[i]   = one_shot[i];
               end else begin
                  w_count_nxt[i] = r_count[i] - 1'b1;
               end
            end
         end
      end
   end

   // State registers; reset start value follows the direction sampled at reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            r_period[i] <= DEFAULT_PERIOD;
            r_count[i]  <= up_not_down[i] ? '0 : DEFAULT_TOP;
         end
         r_tick   <= '0;
         r_square <= '0;
         r_done   <= '0;
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            r_period[i] <= w_period_nxt[i];
            r_count[i]  <= w_count_nxt[i];
         end
         r_tick   <= w_tick_nxt;
         r_square <= w_square_nxt;
         r_done   <= w_done_nxt;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_flat
      assign count_flat[g*WIDTH +: WIDTH] = r_count[g];
   end

   assign tick   = r_tick;
   assign square = r_square;
   assign done   = r_done;

endmodule

// File: tb/tb_timer_bank.sv
// Testbench for timer_bank: per-cycle vector table plus hand-written
// sequences for write/wrap collision and enable-gap stretching.
module tb_timer_bank;

   localparam int unsigned W = 8;
   localparam int unsigned N = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           wr_en;
   logic [3:0]     wr_ch;
   logic [W-1:0]   wr_period;
   logic [N-1:0]   enable;
   logic [N-1:0]   up_not_down;
   logic [N-1:0]   one_shot;
   logic [N-1:0]   tick;
   logic [N-1:0]   square;
   logic [N-1:0]   done;
   logic [N*W-1:0] count_flat;

   int checks   = 0;
   int failures = 0;

   timer_bank #(
      .WIDTH         (W),
      .CHANNELS      (N),
      .DEFAULT_PERIOD(8'd10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_ch      (wr_ch),
      .wr_period  (wr_period),
      .enable     (enable),
      .up_not_down(up_not_down),
      .one_shot   (one_shot),
      .tick       (tick),
      .square     (square),
      .done       (done),
      .count_flat (count_flat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       we;
      logic [3:0] ch;
      logic [7:0] per;
      logic [1:0] en;
      logic [1:0] up;
      logic [1:0] os;
      logic [1:0] e_tick;
      logic [1:0] e_sq;
      logic [1:0] e_done;
      logic [7:0] e_c0;
      logic [7:0] e_c1;
   } vec_t;

   vec_t vecs[$];

   task automatic addv(input logic r, input logic we, input logic [3:0] ch,
                       input logic [7:0] per, input logic [1:0] en,
                       input logic [1:0] up, input logic [1:0] os,
                       input logic [1:0] et, input logic [1:0] es,
                       input logic [1:0] ed, input logic [7:0] c0,
                       input logic [7:0] c1);
      vec_t v;
      v.rst = r; v.we = we; v.ch = ch; v.per = per; v.en = en; v.up = up;
      v.os = os; v.e_tick = et; v.e_sq = es; v.e_done = ed;
      v.e_c0 = c0; v.e_c1 = c1;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic we, input logic [3:0] ch,
                        input logic [7:0] per, input logic [1:0] en,
                        input logic [1:0] up, input logic [1:0] os);
      rst = r; wr_en = we; wr_ch = ch; wr_period = per;
      enable = en; up_not_down = up; one_shot = os;
   endtask

   initial begin
      drive(1'b1, 1'b0, 4'd0, 8'd0, 2'b00, 2'b01, 2'b00);

      //    rst we ch  per   en     up     os     tick   sq     done   c0  c1
      // ch0 up periodic, P=5
      addv(1, 0, 0,  0,  2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0,  9);
      addv(0, 1, 0,  5,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0,  9);
      addv(0, 0, 0,  0,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1,  9);
      addv(0, 0, 0,  0,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2,  9);
      addv(0, 0, 0,  0,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3,  9);
      addv(0, 0, 0,  0,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 4,  9);
      addv(0, 0, 0,  0,  2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 0,  9);
      addv(0, 0, 0,  0,  2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1,  9);
      addv(0, 0, 0,  0,  2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2,  9);
      addv(0, 0, 0,  0,  2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 3,  9);
      addv(0, 0, 0,  0,  2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 4,  9);
      addv(0, 0, 0,  0,  2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 0,  9);
      // ch1 down one-shot, P=4; clearing one_shot keeps done; rewrite resumes
      addv(0, 1, 1,  4,  2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 0,  3);
      addv(0, 0, 0,  0,  2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 0,  2);
      addv(0, 0, 0,  0,  2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 0,  1);
      addv(0, 0, 0,  0,  2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 0,  0);
      addv(0, 0, 0,  0,  2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 0,  3);
      addv(0, 0, 0,  0,  2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b10, 0,  3);
      addv(0, 0, 0,  0,  2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 0,  3);
      addv(0, 1, 1,  4,  2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 0,  3);
      addv(0, 0, 0,  0,  2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 0,  2);
      addv(0, 0, 0,  0,  2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 0,  1);
      // ch0 P=1: tick constantly high, square toggles every cycle
      addv(0, 1, 0,  1,  2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 0,  1);
      addv(0, 0, 0,  0,  2'b01, 2'b01, 2'b00, 2'b01, 2'b11, 2'b00, 0,  1);
      addv(0, 0, 0,  0,  2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 0,  1);
      addv(0, 0, 0,  0,  2'b01, 2'b01, 2'b00, 2'b01, 2'b11, 2'b00, 0,  1);
      // ch0 P=0: idle, C=0, no ticks
      addv(0, 1, 0,  0,  2'b01, 2'b01, 2'b00, 2'b00, 2'b11, 2'b00, 0,  1);
      addv(0, 0, 0,  0,  2'b01, 2'b01, 2'b00, 2'b00, 2'b11, 2'b00, 0,  1);
      addv(0, 0, 0,  0,  2'b01, 2'b01, 2'b00, 2'b00, 2'b11, 2'b00, 0,  1);
      // out-of-range channel writes change nothing (ch1 keeps P=4 below)
      addv(0, 1, 2,  7,  2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 0,  1);
      addv(0, 1, 15, 3,  2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 0,  1);
      addv(0, 0, 0,  0,  2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 0,  0);
      addv(0, 0, 0,  0,  2'b10, 2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 0,  3);
      // reset mid-count wins over a write; down mode reloads DEFAULT-1
      addv(1, 1, 0,  3,  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 9,  9);
      addv(0, 0, 0,  0,  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8,  8);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].we, vecs[i].ch, vecs[i].per,
               vecs[i].en, vecs[i].up, vecs[i].os);
         step();
         chk($sformatf("v%0d_tick", i), 32'(tick),   32'(vecs[i].e_tick));
         chk($sformatf("v%0d_sq", i),   32'(square), 32'(vecs[i].e_sq));
         chk($sformatf("v%0d_done", i), 32'(done),   32'(vecs[i].e_done));
         chk($sformatf("v%0d_c0", i),   32'(count_flat[7:0]),  32'(vecs[i].e_c0));
         chk($sformatf("v%0d_c1", i),   32'(count_flat[15:8]), 32'(vecs[i].e_c1));
      end

      // Write collides with the ch0 wrap edge: write wins, no tick, square holds.
      drive(1'b1, 1'b0, 4'd0, 8'd0, 2'b00, 2'b01, 2'b00);
      step();
      drive(1'b0, 1'b1, 4'd0, 8'd5, 2'b01, 2'b01, 2'b00);
      step();
      drive(1'b0, 1'b0, 4'd0, 8'd0, 2'b01, 2'b01, 2'b00);
      for (int k = 0; k < 4; k++) step();
      chk("coll_pre_c0", 32'(count_flat[7:0]), 32'd4);
      drive(1'b0, 1'b1, 4'd0, 8'd8, 2'b01, 2'b01, 2'b00);
      step();
      chk("coll_tick", 32'(tick[0]), 32'd0);
      chk("coll_sq",   32'(square[0]), 32'd0);
      chk("coll_c0",   32'(count_flat[7:0]), 32'd0);
      drive(1'b0, 1'b0, 4'd0, 8'd0, 2'b01, 2'b01, 2'b00);
      for (int k = 1; k <= 8; k++) begin
         step();
         chk($sformatf("coll_tick_k%0d", k), 32'(tick[0]), (k == 8) ? 32'd1 : 32'd0);
      end
      chk("coll_sq_after", 32'(square[0]), 32'd1);

      // Enable gap on ch0 for 3 cycles stretches its period; ch1 unaffected.
      drive(1'b1, 1'b0, 4'd0, 8'd0, 2'b00, 2'b11, 2'b00);
      step();
      drive(1'b0, 1'b1, 4'd0, 8'd6, 2'b00, 2'b11, 2'b00);
      step();
      drive(1'b0, 1'b1, 4'd1, 8'd6, 2'b00, 2'b11, 2'b00);
      step();
      for (int k = 1; k <= 12; k++) begin
         drive(1'b0, 1'b0, 4'd0, 8'd0,
               {1'b1, !((k >= 3) && (k <= 5))}, 2'b11, 2'b00);
         step();
         chk($sformatf("gap_t0_k%0d", k), 32'(tick[0]), (k == 9) ? 32'd1 : 32'd0);
         chk($sformatf("gap_t1_k%0d", k), 32'(tick[1]),
             ((k == 6) || (k == 12)) ? 32'd1 : 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
